// File: rtl/uart_tx_rm.sv
// uart_tx_rm: memory-mapped 8N1 UART transmitter responding on the shared
// LEGv8 tristate data/address bus. Bytes pushed to TXDATA are queued in a
// small circular FIFO and serialised LSB first by a bit-timing FSM.
module uart_tx_rm #(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_LOG2    = 3
) (
  input  logic        clock,
  input  logic        reset,
  inout  wire  [63:0] data,
  input  logic [31:0] address,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [1:0]  size,
  output logic        tx,
  output logic        irq
);

  localparam int unsigned DEPTH = 1 << FIFO_LOG2;
  localparam int unsigned CW    = FIFO_LOG2 + 1;
  localparam int unsigned TW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [ADDR_WIDTH-1:0] OFF_TXDATA = ADDR_WIDTH'(32'h00);
  localparam logic [ADDR_WIDTH-1:0] OFF_STATUS = ADDR_WIDTH'(32'h08);
  localparam logic [ADDR_WIDTH-1:0] OFF_CTRL   = ADDR_WIDTH'(32'h10);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  // Bus decode
  logic                  hit;
  logic [ADDR_WIDTH-1:0] offset;
  logic                  wr_en;
  logic                  push;
  logic                  ctrl_wr;
  logic                  flush;
  logic                  clr_ovf;

  assign hit     = (address[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH]);
  assign offset  = address[ADDR_WIDTH-1:0];
  assign wr_en   = mem_write & hit;
  assign push    = wr_en & (offset == OFF_TXDATA);
  assign ctrl_wr = wr_en & (offset == OFF_CTRL);
  assign flush   = ctrl_wr & data[1];
  assign clr_ovf = ctrl_wr & data[2];

  // size and the upper write lanes carry nothing this block needs
  logic unused_bits;
  assign unused_bits = ^{size, data[63:8]};

  // FIFO and control state
  logic [7:0]           mem_q [DEPTH];
  logic [FIFO_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 enable_q, enable_d;
  logic                 full, empty, push_ok, pop;

  // Serialiser state
  state_e         state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           tx_q, tx_d;
  logic           busy, can_start, timer_last;

  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign busy       = (state_q != S_IDLE);
  assign can_start  = enable_q & ~empty;
  assign timer_last = (timer_q == TW'(CLKS_PER_BIT - 1));
  // a push into a full FIFO still lands when the serialiser pops on the same edge
  assign push_ok    = push & (~full | pop);

  // Bit-timing FSM: next state, timer, shift register and registered tx value
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tx_d    = 1'b1;
        timer_d = '0;
        bit_d   = '0;
        if (can_start) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (timer_last) begin
          timer_d = '0;
          bit_d   = '0;
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DATA: begin
        if (timer_last) begin
          timer_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_STOP: begin
        if (timer_last) begin
          timer_d = '0;
          bit_d   = '0;
          // chain straight into the next start bit so queued frames have no idle gap
          if (can_start) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = S_START;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Serialiser registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // FIFO pointers, occupancy, sticky overflow and enable bit
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    enable_d = enable_q;
    if (ctrl_wr) begin
      enable_d = data[0];
    end
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end else if (push & full & ~pop) begin
      ovf_d = 1'b1;
    end
    // flush wins over a concurrent pop: the popped byte is already in the shifter
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({push_ok, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO control registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      enable_q <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      enable_q <= enable_d;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data[7:0];
    end
  end

  // Register read mux, zero-extended to the bus width
  logic [63:0] rdata;
  always_comb begin
    rdata = '0;
    unique case (offset)
      OFF_STATUS: begin
        rdata[0]       = busy;
        rdata[1]       = full;
        rdata[2]       = empty;
        rdata[3]       = ovf_q;
        rdata[8 +: CW] = count_q;
      end
      OFF_CTRL: begin
        rdata[0] = enable_q;
      end
      default: rdata = '0;
    endcase
  end

  assign data = (mem_read & hit) ? rdata : 'z;
  assign tx   = tx_q;
  assign irq  = empty & ~busy & enable_q;

endmodule
